// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle between four operand requesters, one result consumer
// and the shared-multiplier arbiter. The arbiter uses the slave modport.
interface mult_share_arbiter_if;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_o;
  logic [1:0]  rsp_id;
  logic        busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_o, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_o, rsp_id, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Four requesters share one 16x16 unsigned multiplier. A round-robin
// arbiter grants one requester in IDLE, the product is registered after a
// single CALC cycle, and RESP holds the result until the consumer takes it.

// Plain combinational 16x16 -> 32 unsigned multiplier.
module multiplier_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] o
);
  assign o = a * b;
endmodule

module mult_share_arbiter (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      state_q;
  logic [1:0]  last_grant_q;
  logic [15:0] op_a_q;
  logic [15:0] op_b_q;
  logic [31:0] rsp_o_q;
  logic [1:0]  rsp_id_q;
  logic        rsp_valid_q;
  logic        busy_q;

  logic [1:0]  grant_d;
  logic        grant_vld_d;
  logic [31:0] mult_o;
  logic [15:0] req_a_w [4];
  logic [15:0] req_b_w [4];

  // Unpack the flat operand buses into per-requester lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign req_a_w[gi] = bus.req_a[16*gi +: 16];
      assign req_b_w[gi] = bus.req_b[16*gi +: 16];
    end
  endgenerate

  // Round-robin pick: scan from farthest to nearest after last_grant so the
  // nearest valid requester (last_grant+1, wrapping) overrides the others.
  always_comb begin
    logic [1:0] idx;
    grant_d     = 2'd0;
    grant_vld_d = 1'b0;
    idx         = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant_q + 2'(k);
      if (bus.req_valid[idx]) begin
        grant_d     = idx;
        grant_vld_d = 1'b1;
      end
    end
  end

  // Accept is combinational and only offered in IDLE; masked while in reset.
  assign bus.req_ready = (state_q == IDLE && grant_vld_d && rst_n)
                         ? (4'b0001 << grant_d) : 4'b0000;

  // The single shared multiplier always sees the latched operands.
  multiplier_16bit u_mult (
    .a (op_a_q),
    .b (op_b_q),
    .o (mult_o)
  );

  // Arbitration / compute / response FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_o_q      <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            op_a_q       <= req_a_w[grant_d];
            op_b_q       <= req_b_w[grant_d];
            rsp_id_q     <= grant_d;
            last_grant_q <= grant_d;
            busy_q       <= 1'b1;
            state_q      <= CALC;
          end
        end
        CALC: begin
          rsp_o_q     <= mult_o;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_o     = rsp_o_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin / product model.
// All driving and sampling happens in the low half of the clock.
module tb_mult_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_share_arbiter_if bus ();

  mult_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int last_m = 3;
  int cyc = 0;
  logic [15:0] a_m [4];
  logic [15:0] b_m [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arbitration: first valid requester after the last grant.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[16*i +: 16] = a_m[i];
      bus.req_b[16*i +: 16] = b_m[i];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin a_m[i] = '0; b_m[i] = '0; end
    drive_ops();
    repeat (2) tick();
    rst_n = 1'b1;
    last_m = 3;
  endtask

  // Stimulus driver for one transaction; returns what it observed.
  task automatic do_txn(input logic [3:0] v, input int stall, input bit scramble,
                        output bit gok, output logic [3:0] rdy, output bit rok,
                        output logic [31:0] prod, output logic [1:0] id,
                        output bit stable);
    bus.req_valid = v;
    bus.rsp_ready = 1'b0;
    drive_ops();
    gok = 0; rok = 0; stable = 1; rdy = '0; prod = '0; id = '0;
    for (int i = 0; i < 8 && !gok; i++) begin
      settle();
      if (bus.req_ready != 4'b0) gok = 1;
      else tick();
    end
    rdy = bus.req_ready;
    tick();
    if (scramble) begin
      for (int i = 0; i < 4; i++) begin
        a_m[i] = 16'($urandom); b_m[i] = 16'($urandom);
      end
      drive_ops();
      bus.req_valid = 4'($urandom);
    end
    for (int i = 0; i < 6 && !rok; i++) begin
      settle();
      if (bus.rsp_valid === 1'b1) rok = 1;
      else tick();
    end
    prod = bus.rsp_o;
    id = bus.rsp_id;
    for (int s = 0; s < stall; s++) begin
      tick();
      settle();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_o !== prod || bus.rsp_id !== id ||
          bus.req_ready !== 4'b0 || bus.busy !== 1'b1) stable = 0;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    $display("txn: valid=%b ready=%b id=%0d product=%0d stall=%0d", v, rdy, id, prod, stall);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin a_m[i] = 16'(i + 5); b_m[i] = 16'd3; end
    drive_ops();
    tick();
    settle();
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rsp_o !== 32'd0) begin errors++; $display("FAIL reset_rsp_o: got %h expected 0", bus.rsp_o); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
    apply_reset();
  endtask

  task automatic test_single();
    int g;
    a_m[1] = 16'd20; b_m[1] = 16'd29;
    drive_ops();
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    settle();
    g = rr_pick(4'b0010, last_m);
    checks++; if (bus.req_ready !== 4'(1 << g) || bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected %b", bus.req_ready, 4'(1 << g)); end
    last_m = g;
    tick();
    bus.req_valid = 4'b0;
    settle();
    checks++; if (bus.req_ready !== 4'b0 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc: got ready=%b busy=%b rsp_valid=%b expected 0000/1/0", bus.req_ready, bus.busy, bus.rsp_valid); end
    tick();
    settle();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_o !== 32'd580 || bus.rsp_id !== 2'd1) begin errors++; $display("FAIL single_rsp: got v=%b o=%0d id=%0d expected 1/580/1", bus.rsp_valid, bus.rsp_o, bus.rsp_id); end
    $display("txn: single id=%0d product=%0d", bus.rsp_id, bus.rsp_o);
    tick();
    settle();
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b rsp_valid=%b expected 0/0", bus.busy, bus.rsp_valid); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    bit gok, rok, stable;
    logic [3:0] rdy;
    logic [31:0] prod;
    logic [1:0] id;
    int g;
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) begin a_m[i] = 16'(i + 1); b_m[i] = 16'd1000; end
      g = rr_pick(4'b1111, last_m);
      do_txn(4'b1111, 0, 1'b0, gok, rdy, rok, prod, id, stable);
      checks++; if (!gok || rdy !== 4'(1 << (t % 4)) || rdy !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", t, rdy, 4'(1 << (t % 4))); end
      checks++; if (!rok || prod !== 32'((g + 1) * 1000) || id !== 2'(g)) begin errors++; $display("FAIL rr_rsp%0d: got o=%0d id=%0d expected o=%0d id=%0d", t, prod, id, (g + 1) * 1000, g); end
      last_m = g;
    end
    bus.req_valid = 4'b0;
  endtask

  task automatic test_corner();
    bit gok, rok, stable;
    logic [3:0] rdy;
    logic [31:0] prod;
    logic [1:0] id;
    logic [31:0] exp_p;
    int rq [2] = '{2, 3};
    logic [15:0] ta [2] = '{16'hFFFF, 16'd210};
    logic [15:0] tb [2] = '{16'hFFFF, 16'd2239};
    for (int t = 0; t < 2; t++) begin
      a_m[rq[t]] = ta[t]; b_m[rq[t]] = tb[t];
      exp_p = 32'(ta[t]) * 32'(tb[t]);
      do_txn(4'(1 << rq[t]), 1, 1'b0, gok, rdy, rok, prod, id, stable);
      checks++; if (!gok || rdy !== 4'(1 << rq[t])) begin errors++; $display("FAIL corner_grant%0d: got %b expected %b", t, rdy, 4'(1 << rq[t])); end
      checks++; if (!rok || prod !== exp_p || id !== 2'(rq[t]) || !stable) begin errors++; $display("FAIL corner_rsp%0d: got o=%h id=%0d stable=%0d expected o=%h id=%0d", t, prod, id, stable, exp_p, rq[t]); end
      last_m = rq[t];
    end
    bus.req_valid = 4'b0;
  endtask

  task automatic test_backpressure();
    int g;
    a_m[0] = 16'd8; b_m[0] = 16'd2;
    drive_ops();
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    settle();
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b expected 0001", bus.req_ready); end
    last_m = 0;
    tick();
    bus.req_valid = 4'b1111;
    tick();
    settle();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_latency: got rsp_valid=%b expected 1", bus.rsp_valid); end
    for (int s = 0; s < 5; s++) begin
      tick();
      settle();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_o !== 32'd16 || bus.rsp_id !== 2'd0 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b o=%0d id=%0d busy=%b ready=%b expected 1/16/0/1/0000", s, bus.rsp_valid, bus.rsp_o, bus.rsp_id, bus.busy, bus.req_ready);
      end
    end
    $display("txn: backpressure id=%0d product=%0d", bus.rsp_id, bus.rsp_o);
    bus.rsp_ready = 1'b1;
    tick();
    settle();
    g = rr_pick(4'b1111, last_m);
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL bp_release: got busy=%b v=%b ready=%b expected 0/0/%b", bus.busy, bus.rsp_valid, bus.req_ready, 4'(1 << g)); end
    bus.req_valid = 4'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_m[0] = 16'd200; b_m[0] = 16'd29;
    drive_ops();
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    settle();
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rm_grant: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1111;
    rst_n = 1'b0;
    settle();
    checks++;
    if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_o !== 32'd0 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL rm_async: got ready=%b v=%b busy=%b o=%0d id=%0d expected all zero", bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_o, bus.rsp_id);
    end
    tick();
    rst_n = 1'b1;
    last_m = 3;
    settle();
    checks++; if (bus.req_ready !== 4'(1 << rr_pick(4'b1111, last_m)) || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_regrant: got ready=%b v=%b expected 0001/0", bus.req_ready, bus.rsp_valid); end
    last_m = 0;
    tick();
    bus.req_valid = 4'b0;
    tick();
    settle();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_o !== 32'd5800 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rm_rsp: got v=%b o=%0d id=%0d expected 1/5800/0", bus.rsp_valid, bus.rsp_o, bus.rsp_id); end
    $display("txn: after-reset id=%0d product=%0d", bus.rsp_id, bus.rsp_o);
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int hs = 0;
    int rc [2] = '{0, 0};
    logic [31:0] rv [2] = '{32'hX, 32'hX};
    a_m[0] = 16'd0; b_m[0] = 16'd0;
    drive_ops();
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12 && n < 2; i++) begin
      settle();
      if (bus.rsp_valid === 1'b1) begin
        rc[n] = cyc; rv[n] = bus.rsp_o; n++;
        $display("txn: b2b id=%0d product=%0d cycle=%0d", bus.rsp_id, bus.rsp_o, cyc);
      end
      if (bus.req_ready[0] === 1'b1) hs++;
      tick();
      if (hs == 1) begin a_m[0] = 16'd2; b_m[0] = 16'd29; drive_ops(); end
    end
    bus.req_valid = 4'b0;
    bus.rsp_ready = 1'b0;
    last_m = 0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count: got %0d responses expected 2", n); end
    checks++; if (rv[0] !== 32'd0 || rv[1] !== 32'd58) begin errors++; $display("FAIL b2b_values: got %0d,%0d expected 0,58", rv[0], rv[1]); end
    checks++; if (rc[1] - rc[0] !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 3", rc[1] - rc[0]); end
  endtask

  task automatic test_random();
    bit gok, rok, stable;
    logic [3:0] rdy;
    logic [31:0] prod;
    logic [1:0] id;
    logic [3:0] v;
    logic [31:0] exp_p;
    int g;
    int stall;
    for (int t = 0; t < 40; t++) begin
      v = 4'($urandom_range(1, 15));
      stall = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin a_m[i] = 16'($urandom); b_m[i] = 16'($urandom); end
      g = rr_pick(v, last_m);
      exp_p = 32'(a_m[g]) * 32'(b_m[g]);
      do_txn(v, stall, 1'b1, gok, rdy, rok, prod, id, stable);
      checks++; if (!gok || rdy !== 4'(1 << g)) begin errors++; $display("FAIL rand_grant%0d: got %b expected %b", t, rdy, 4'(1 << g)); end
      checks++; if (!rok || prod !== exp_p || id !== 2'(g)) begin errors++; $display("FAIL rand_rsp%0d: got o=%0d id=%0d expected o=%0d id=%0d", t, prod, id, exp_p, g); end
      checks++; if (!stable) begin errors++; $display("FAIL rand_hold%0d: got unstable response expected stable for %0d cycles", t, stall); end
      last_m = g;
    end
    bus.req_valid = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_corner();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
